sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
Downstream neighbour of the CPU core: turns the core's single-cycle inst/data SRAM ports into AXI3 single-beat transactions. At most one outstanding AXI transaction at a time. Holds the core with stallreq_from_bridge until every enabled port in the current core cycle has been served. Sits in the CPU top between the core and the AXI crossbar.

Parameters:
INST_ID, 4'd0, ARID for instruction fetches
DATA_ID, 4'd1, ARID for data loads

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
inst_sram_en  in  1  fetch request this core cycle
inst_sram_addr  in  32  fetch address
inst_sram_rdata  out  32  fetched word, registered
data_sram_en  in  1  data access request this core cycle
data_sram_wen  in  4  byte write enables; 0 = load
data_sram_addr  in  32  data address
data_sram_wdata  in  32  store data
data_sram_rdata  out  32  loaded word, registered
stallreq_from_bridge  out  1  freeze the whole pipeline (ORed into CTRL)
arid  out  4  read ID
araddr  out  32  read address
arsize  out  3  read size, always 3'd2
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awsize  out  3  write size derived from wen
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes = data_sram_wen
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready
(arlen/awlen=0, wlast=1, burst/lock/cache/prot/wid/awid are tied constants in the top, not ports.)

Behaviour:
- Reset values: all valids/readies 0; state IDLE; inst_done = data_done = 0; both rdata registers 0; stall 0.
- Stall rule: stallreq_from_bridge = (inst_sram_en & !inst_done) | (data_sram_en & !data_done). Combinational from the registered done flags.
- Cycle completion: in any cycle with stall = 0, both done flags clear at the next edge, so the core advances exactly one step per served request.
- FSM states:
  - IDLE: if data_sram_en & !data_done: go to D_WR when wen != 0, else D_AR. Otherwise, if inst_sram_en & !inst_done: go to I_AR. Data always wins over inst.
  - D_AR / I_AR: arvalid = 1, araddr = the port address, arid = DATA_ID / INST_ID. On arready, go to D_R / I_R.
  - D_R / I_R: rready = 1. On rvalid, capture rdata into the port's rdata register, set that port's done flag, return to IDLE.
  - D_WR: assert awvalid and wvalid together. Each drops independently when its own ready is seen; track aw_ok / w_ok. When both are ok, go to D_B.
  - D_B: bready = 1. On bvalid, set data_done and return to IDLE.
- Request stability: AXI address/data/strobe outputs come from internally latched request registers, captured on the IDLE exit. They stay stable while valid is high even if core inputs glitch.
- awsize: wen 4'b1111 gives 2; 4'b0011 or 4'b1100 gives 1; one-hot gives 0. Any other non-zero pattern gives 2. wdata is passed unshifted.
- Read data: inst_sram_rdata and data_sram_rdata hold their last captured value until the next capture on the same port.
- Latency: minimum 3 cycles per read (IDLE, AR, R). A load plus fetch in the same core cycle takes at least 6 cycles of stall.
- Error responses: rresp/bresp are ignored; data is captured regardless.
- Reset mid-transaction: returns to IDLE immediately and drops all valids. Acceptable only because the interconnect shares rst.
- Write-only core cycle (data write, no fetch): inst_done is irrelevant and stall depends only on data_done.

Decomposition:
- Shared package (lib/defines.vh): FSM state encodings, AXI size constants, the INST_ID/DATA_ID defaults.
- No sub-module. A single FSM with request latches is natural. The optional wen-to-awsize function lives in the same file.

Test Plan:
- Fetch only: inst_en=1, addr=0xBFC00000, slave arready after 2 cycles, rdata=0x3C010001 → arid=0, stall high 4 cycles, inst_sram_rdata=0x3C010001, then stall low for 1 cycle.
- Load + fetch same cycle: data_en=1, wen=0, addr=0x80001000 (mem 0x12345678) → AR for 0x80001000 with arid=1 first, then the fetch AR. data_sram_rdata=0x12345678, stall drops only after the fetch completes.
- Store word with wready before awready: wen=4'b1111, wdata=0xDEADBEEF → wvalid drops after wready while awvalid stays high, bready asserted after both. awsize=2, wstrb=4'hF, no read issued.
- Byte store: wen=4'b0100 → awsize=0, wstrb=4'b0100. Halfword wen=4'b1100 → awsize=1.
- Async reset asserted while in D_R → all valids/readies 0 in the same cycle, stall 0, rdata registers 0. After release, a fresh fetch works normally.
- Back-to-back fetches with arready=rvalid=1 always → exactly one stall-free cycle between successive 3-cycle fetches, IDs always 0.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants for the SRAM-to-AXI3 bridge: FSM encodings, AXI size codes,
// default transaction IDs and the write-enable to AXI size mapping.
package sram_axi_bridge_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_D_AR = 3'd1;
    localparam logic [2:0] S_D_R  = 3'd2;
    localparam logic [2:0] S_I_AR = 3'd3;
    localparam logic [2:0] S_I_R  = 3'd4;
    localparam logic [2:0] S_D_WR = 3'd5;
    localparam logic [2:0] S_D_B  = 3'd6;

    localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
    localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
    localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

    // Irregular strobe patterns fall back to a full-word size; wstrb still masks bytes.
    function automatic logic [2:0] wen_to_size(input logic [3:0] wen);
        logic [2:0] size;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = AXI_SIZE_BYTE;
            4'b0011, 4'b1100:                   size = AXI_SIZE_HALF;
            default:                            size = AXI_SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Converts the core's single-cycle inst/data SRAM ports into single-beat AXI3
// transactions, one outstanding at a time, stalling the core until all are served.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
    parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,

    output logic        stallreq_from_bridge,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    logic [2:0]  state;
    logic        inst_done;
    logic        data_done;
    logic        aw_ok;
    logic        w_ok;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        data_pend;
    logic        inst_pend;

    assign data_pend = data_sram_en & ~data_done;
    assign inst_pend = inst_sram_en & ~inst_done;
    assign stallreq_from_bridge = data_pend | inst_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            inst_done    <= 1'b0;
            data_done    <= 1'b0;
            aw_ok        <= 1'b0;
            w_ok         <= 1'b0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            // A stall-free cycle means the core advances, so the next step starts fresh.
            if (!stallreq_from_bridge) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (data_pend) begin
                        state <= (data_sram_wen != 4'd0) ? S_D_WR : S_D_AR;
                    end else if (inst_pend) begin
                        state <= S_I_AR;
                    end
                end
                S_D_AR: if (arready) state <= S_D_R;
                S_I_AR: if (arready) state <= S_I_R;
                S_D_R: begin
                    if (rvalid) begin
                        data_rdata_q <= rdata;
                        data_done    <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                S_I_R: begin
                    if (rvalid) begin
                        inst_rdata_q <= rdata;
                        inst_done    <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                S_D_WR: begin
                    if ((aw_ok | awready) && (w_ok | wready)) begin
                        aw_ok <= 1'b0;
                        w_ok  <= 1'b0;
                        state <= S_D_B;
                    end else begin
                        aw_ok <= aw_ok | awready;
                        w_ok  <= w_ok | wready;
                    end
                end
                S_D_B: begin
                    if (bvalid) begin
                        data_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request latches: captured on leaving IDLE so AXI payload ignores later core glitches.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            if (data_pend) begin
                req_addr  <= data_sram_addr;
                req_wdata <= data_sram_wdata;
                req_wstrb <= data_sram_wen;
            end else if (inst_pend) begin
                req_addr  <= inst_sram_addr;
            end
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;

    assign arvalid = (state == S_D_AR) || (state == S_I_AR);
    assign arid    = (state == S_D_AR) ? DATA_ID : INST_ID;
    assign araddr  = req_addr;
    assign arsize  = AXI_SIZE_WORD;
    assign rready  = (state == S_D_R) || (state == S_I_R);

    assign awvalid = (state == S_D_WR) && !aw_ok;
    assign wvalid  = (state == S_D_WR) && !w_ok;
    assign awaddr  = req_addr;
    assign awsize  = wen_to_size(req_wstrb);
    assign wdata   = req_wdata;
    assign wstrb   = req_wstrb;
    assign bready  = (state == S_D_B);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays both the core and the AXI slave.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_en = 1'b0;
    logic [31:0] inst_sram_addr = 32'd0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'd0;
    logic [31:0] data_sram_addr = 32'd0;
    logic [31:0] data_sram_wdata = 32'd0;
    logic [31:0] data_sram_rdata;
    logic        stallreq_from_bridge;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic        bready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stallreq_from_bridge(stallreq_from_bridge),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
        chk({tag, "_rready"},  {31'd0, rready},  32'd0);
        chk({tag, "_awvalid"}, {31'd0, awvalid}, 32'd0);
        chk({tag, "_wvalid"},  {31'd0, wvalid},  32'd0);
        chk({tag, "_bready"},  {31'd0, bready},  32'd0);
    endtask

    initial begin
        // Reset state
        step(); #1;
        chk_idle_bus("rst");
        chk("rst_stall", {31'd0, stallreq_from_bridge}, 32'd0);
        chk("rst_irdata", inst_sram_rdata, 32'd0);
        chk("rst_drdata", data_sram_rdata, 32'd0);
        rst = 1'b0;

        // Fetch only, arready on second AR cycle
        step(); inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000; #1;
        chk("f1_stall_idle", {31'd0, stallreq_from_bridge}, 32'd1);
        chk("f1_arvalid_idle", {31'd0, arvalid}, 32'd0);
        step(); #1;
        chk("f1_arvalid", {31'd0, arvalid}, 32'd1);
        chk("f1_araddr", araddr, 32'hBFC0_0000);
        chk("f1_arid", {28'd0, arid}, 32'd0);
        chk("f1_arsize", {29'd0, arsize}, 32'd2);
        chk("f1_stall_ar1", {31'd0, stallreq_from_bridge}, 32'd1);
        step(); arready = 1'b1; #1;
        chk("f1_stall_ar2", {31'd0, stallreq_from_bridge}, 32'd1);
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h3C01_0001; #1;
        chk("f1_rready", {31'd0, rready}, 32'd1);
        chk("f1_arvalid_r", {31'd0, arvalid}, 32'd0);
        chk("f1_stall_r", {31'd0, stallreq_from_bridge}, 32'd1);
        step(); rvalid = 1'b0; rdata = 32'd0; #1;
        chk("f1_stall_done", {31'd0, stallreq_from_bridge}, 32'd0);
        chk("f1_irdata", inst_sram_rdata, 32'h3C01_0001);
        inst_sram_en = 1'b0;
        step(); #1;
        chk("f1_stall_after", {31'd0, stallreq_from_bridge}, 32'd0);
        chk("f1_arvalid_after", {31'd0, arvalid}, 32'd0);

        // Load + fetch in the same core cycle: load goes first
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h8000_1000;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0004;
        step(); #1;
        chk("lf_araddr_d", araddr, 32'h8000_1000);
        chk("lf_arid_d", {28'd0, arid}, 32'd1);
        chk("lf_arvalid_d", {31'd0, arvalid}, 32'd1);
        arready = 1'b1;
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; #1;
        chk("lf_rready_d", {31'd0, rready}, 32'd1);
        step(); rvalid = 1'b0; #1;
        chk("lf_drdata", data_sram_rdata, 32'h1234_5678);
        chk("lf_stall_mid", {31'd0, stallreq_from_bridge}, 32'd1);
        chk("lf_arvalid_gap", {31'd0, arvalid}, 32'd0);
        step(); #1;
        chk("lf_araddr_i", araddr, 32'hBFC0_0004);
        chk("lf_arid_i", {28'd0, arid}, 32'd0);
        arready = 1'b1;
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111; #1;
        chk("lf_stall_ir", {31'd0, stallreq_from_bridge}, 32'd1);
        step(); rvalid = 1'b0; #1;
        chk("lf_stall_done", {31'd0, stallreq_from_bridge}, 32'd0);
        chk("lf_irdata", inst_sram_rdata, 32'h1111_1111);
        chk("lf_drdata_hold", data_sram_rdata, 32'h1234_5678);
        inst_sram_en = 1'b0; data_sram_en = 1'b0;

        // Store word, wready before awready
        step();
        data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h8000_2000;
        data_sram_wdata = 32'hDEAD_BEEF;
        step(); #1;
        chk("sw_awvalid", {31'd0, awvalid}, 32'd1);
        chk("sw_wvalid", {31'd0, wvalid}, 32'd1);
        chk("sw_awaddr", awaddr, 32'h8000_2000);
        chk("sw_awsize", {29'd0, awsize}, 32'd2);
        chk("sw_wstrb", {28'd0, wstrb}, 32'hF);
        chk("sw_wdata", wdata, 32'hDEAD_BEEF);
        chk("sw_arvalid", {31'd0, arvalid}, 32'd0);
        wready = 1'b1;
        step(); wready = 1'b0; #1;
        chk("sw_wvalid_drop", {31'd0, wvalid}, 32'd0);
        chk("sw_awvalid_hold", {31'd0, awvalid}, 32'd1);
        chk("sw_bready_early", {31'd0, bready}, 32'd0);
        awready = 1'b1;
        step(); awready = 1'b0; #1;
        chk("sw_bready", {31'd0, bready}, 32'd1);
        chk("sw_awvalid_drop", {31'd0, awvalid}, 32'd0);
        chk("sw_arvalid_b", {31'd0, arvalid}, 32'd0);
        chk("sw_stall_b", {31'd0, stallreq_from_bridge}, 32'd1);
        bvalid = 1'b1;
        step(); bvalid = 1'b0; #1;
        chk("sw_stall_done", {31'd0, stallreq_from_bridge}, 32'd0);
        data_sram_en = 1'b0;

        // Byte store, with core inputs glitching after capture
        step();
        data_sram_en = 1'b1; data_sram_wen = 4'b0100; data_sram_addr = 32'h8000_2002;
        data_sram_wdata = 32'h00AB_0000;
        step(); data_sram_addr = 32'h0000_0000; data_sram_wdata = 32'hFFFF_FFFF; #1;
        chk("sb_awsize", {29'd0, awsize}, 32'd0);
        chk("sb_wstrb", {28'd0, wstrb}, 32'h4);
        chk("sb_awaddr_stable", awaddr, 32'h8000_2002);
        chk("sb_wdata_stable", wdata, 32'h00AB_0000);
        awready = 1'b1; wready = 1'b1;
        step(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; #1;
        chk("sb_bready", {31'd0, bready}, 32'd1);
        step(); bvalid = 1'b0; #1;
        chk("sb_stall_done", {31'd0, stallreq_from_bridge}, 32'd0);
        data_sram_en = 1'b0;

        // Halfword store
        step();
        data_sram_en = 1'b1; data_sram_wen = 4'b1100; data_sram_addr = 32'h8000_2004;
        data_sram_wdata = 32'hBEEF_0000;
        step(); #1;
        chk("sh_awsize", {29'd0, awsize}, 32'd1);
        chk("sh_wstrb", {28'd0, wstrb}, 32'hC);
        awready = 1'b1; wready = 1'b1;
        step(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        step(); bvalid = 1'b0; #1;
        chk("sh_stall_done", {31'd0, stallreq_from_bridge}, 32'd0);
        data_sram_en = 1'b0;

        // Asynchronous reset while a load sits in D_R
        step();
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h8000_3000;
        step(); arready = 1'b1;
        step(); arready = 1'b0; #1;
        chk("ar_rready_pre", {31'd0, rready}, 32'd1);
        #1; rst = 1'b1; data_sram_en = 1'b0; #1;
        chk_idle_bus("arst");
        chk("arst_stall", {31'd0, stallreq_from_bridge}, 32'd0);
        chk("arst_irdata", inst_sram_rdata, 32'd0);
        chk("arst_drdata", data_sram_rdata, 32'd0);
        step(); rst = 1'b0;

        // Back-to-back fetches with an always-ready slave
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hC0DE_0000;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0100;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("bb_stall_%0d", i), {31'd0, stallreq_from_bridge},
                {31'd0, (i % 4) != 3});
            chk($sformatf("bb_arvalid_%0d", i), {31'd0, arvalid}, {31'd0, (i % 4) == 1});
            if ((i % 4) == 1) chk($sformatf("bb_arid_%0d", i), {28'd0, arid}, 32'd0);
            if ((i % 4) == 3) chk($sformatf("bb_irdata_%0d", i), inst_sram_rdata, 32'hC0DE_0000);
            step();
        end
        inst_sram_en = 1'b0; arready = 1'b0; rvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
